// File: rtl/repl_pkg.sv
// Shared types for the set replacement controller.
// Policy selector, flush FSM states, LFSR tap mask.
package repl_pkg;

  typedef enum logic [1:0] {
    REPL_PLRU,
    REPL_FIFO,
    REPL_RANDOM
  } repl_policy_t;

  typedef enum logic {
    RS_IDLE,
    RS_FLUSH
  } repl_state_t;

  // x^16+x^14+x^13+x^11+1, right-shifting form:
  // feedback = l[0]^l[2]^l[3]^l[5], shifted into bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/plru_tree_pick.sv
// Tree-PLRU victim walk honouring an availability mask.
// Ports: tree_i node bits [W-1:1], avail_i per-way mask, way_o pick.
module plru_tree_pick #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-1:0]         tree_i,
  input  logic [NUM_WAYS-1:0]         avail_i,
  output logic [$clog2(NUM_WAYS)-1:0] way_o
);
  localparam int WW = $clog2(NUM_WAYS);

  logic [2*NUM_WAYS-1:0] sub;
  logic                  unused_bits;

  assign unused_bits = ^{sub[0], tree_i[0]};

  // sub[n] = subtree under node n holds an available way
  always_comb begin
    int  n;
    logic dir;
    sub = '0;
    n   = 1;
    dir = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      sub[NUM_WAYS+w] = avail_i[w];
    for (int i = NUM_WAYS - 1; i >= 1; i--)
      sub[i] = sub[2*i] | sub[2*i+1];
    for (int l = 0; l < WW; l++) begin
      dir = tree_i[n];
      if (dir && !sub[2*n+1])
        dir = 1'b0;
      else if (!dir && !sub[2*n])
        dir = 1'b1;
      n = 2 * n + int'(dir);
    end
    way_o = WW'(n - NUM_WAYS);
  end

endmodule

// File: rtl/set_repl_ctrl.sv
// Per-set replacement controller: PLRU/FIFO/random, valid, lock, flush.
// Ports: touch/inval updates, query -> registered victim, flush/busy.
module set_repl_ctrl
  import repl_pkg::*;
#(
  parameter int          NUM_WAYS  = 4,
  parameter int          NUM_SETS  = 8,
  parameter int          POLICY    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         touch_valid,
  input  logic                         touch_fill,
  input  logic [$clog2(NUM_SETS)-1:0]  touch_set,
  input  logic [$clog2(NUM_WAYS)-1:0]  touch_way,
  input  logic                         inval_valid,
  input  logic [$clog2(NUM_SETS)-1:0]  inval_set,
  input  logic [$clog2(NUM_WAYS)-1:0]  inval_way,
  input  logic                         query_valid,
  input  logic [$clog2(NUM_SETS)-1:0]  query_set,
  input  logic [NUM_WAYS-1:0]          lock_mask,
  output logic                         victim_valid,
  output logic [$clog2(NUM_WAYS)-1:0]  victim_way,
  output logic                         victim_none,
  input  logic                         flush,
  output logic                         busy
);
  localparam int WW = $clog2(NUM_WAYS);
  localparam int SW = $clog2(NUM_SETS);
  localparam repl_policy_t POL = repl_policy_t'(POLICY);

  logic [NUM_WAYS-1:0] tree_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] tree_d  [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [WW-1:0]       ptr_q   [NUM_SETS];
  logic [WW-1:0]       ptr_d   [NUM_SETS];
  logic [15:0]         lfsr_q, lfsr_d;
  repl_state_t         st_q, st_d;
  logic [SW-1:0]       cnt_q, cnt_d;

  logic                vv_q;
  logic [WW-1:0]       vway_q, vway_d;
  logic                vnone_q, vnone_d;

  logic [NUM_WAYS-1:0] avail, inv_avail;
  logic [WW-1:0]       plru_way;
  logic [WW-1:0]       start;

  assign busy         = (st_q == RS_FLUSH);
  assign victim_valid = vv_q;
  assign victim_way   = vway_q;
  assign victim_none  = vnone_q;

  // Next-state: touch first, then inval, so inval wins on a clash.
  always_comb begin
    int n;
    n       = 0;
    tree_d  = tree_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    lfsr_d  = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    unique case (st_q)
      RS_IDLE: begin
        if (touch_valid) begin
          if (POL == REPL_PLRU) begin
            n = NUM_WAYS + int'(touch_way);
            for (int l = 0; l < WW; l++) begin
              tree_d[touch_set][n/2] = ~n[0];
              n = n / 2;
            end
          end
          if (touch_fill) begin
            valid_d[touch_set][touch_way] = 1'b1;
            ptr_d[touch_set] = touch_way + WW'(1);
          end
        end
        if (inval_valid) begin
          valid_d[inval_set][inval_way] = 1'b0;
          if (POL == REPL_PLRU) begin
            n = NUM_WAYS + int'(inval_way);
            for (int l = 0; l < WW; l++) begin
              tree_d[inval_set][n/2] = n[0];
              n = n / 2;
            end
          end
        end
        if (flush) begin
          st_d  = RS_FLUSH;
          cnt_d = '0;
        end
      end
      RS_FLUSH: begin
        tree_d[cnt_q]  = '0;
        valid_d[cnt_q] = '0;
        ptr_d[cnt_q]   = '0;
        cnt_d          = cnt_q + SW'(1);
        if (cnt_q == SW'(NUM_SETS - 1))
          st_d = RS_IDLE;
      end
      default: st_d = RS_IDLE;
    endcase
  end

  assign avail     = ~lock_mask;
  assign inv_avail = avail & ~valid_q[query_set];
  assign start     = (POL == REPL_FIFO) ? ptr_q[query_set]
                                        : lfsr_q[WW-1:0];

  plru_tree_pick #(
    .NUM_WAYS (NUM_WAYS)
  ) u_pick (
    .tree_i  (tree_q[query_set]),
    .avail_i (avail),
    .way_o   (plru_way)
  );

  // Downward loops so the lowest qualifying index is the last write.
  always_comb begin
    logic [WW-1:0] idx;
    idx     = '0;
    vway_d  = '0;
    vnone_d = 1'b0;
    if (avail == '0) begin
      vnone_d = 1'b1;
    end else if (inv_avail != '0) begin
      for (int w = NUM_WAYS - 1; w >= 0; w--)
        if (inv_avail[w]) vway_d = WW'(w);
    end else if (POL == REPL_PLRU) begin
      vway_d = plru_way;
    end else begin
      for (int k = NUM_WAYS - 1; k >= 0; k--) begin
        idx = start + WW'(k);
        if (avail[idx]) vway_d = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      lfsr_q  <= LFSR_SEED;
      st_q    <= RS_IDLE;
      cnt_q   <= '0;
      vv_q    <= 1'b0;
      vway_q  <= '0;
      vnone_q <= 1'b0;
    end else begin
      tree_q  <= tree_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      vv_q    <= query_valid && (st_q == RS_IDLE);
      if (query_valid && (st_q == RS_IDLE)) begin
        vway_q  <= vway_d;
        vnone_q <= vnone_d;
      end
    end
  end

endmodule

// File: tb/tb_set_repl_ctrl.sv
// Bench for set_repl_ctrl: PLRU, FIFO and random instances in parallel.
// Range-halving reference model, directed cases then random traffic.
module tb_set_repl_ctrl;
  localparam int NW = 4;
  localparam int NS = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       touch_valid, touch_fill;
  logic [2:0] touch_set;
  logic [1:0] touch_way;
  logic       inval_valid;
  logic [2:0] inval_set;
  logic [1:0] inval_way;
  logic       query_valid;
  logic [2:0] query_set;
  logic [3:0] lock_mask;
  logic       flush;

  logic       vv [3];
  logic [1:0] vw [3];
  logic       vn [3];
  logic       bz [3];

  always #5 clk = ~clk;

  set_repl_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS), .POLICY(0),
                  .LFSR_SEED(16'hACE1)) u_plru (
    .clk(clk), .reset(reset),
    .touch_valid(touch_valid), .touch_fill(touch_fill),
    .touch_set(touch_set), .touch_way(touch_way),
    .inval_valid(inval_valid), .inval_set(inval_set),
    .inval_way(inval_way),
    .query_valid(query_valid), .query_set(query_set),
    .lock_mask(lock_mask),
    .victim_valid(vv[0]), .victim_way(vw[0]),
    .victim_none(vn[0]), .flush(flush), .busy(bz[0]));

  set_repl_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS), .POLICY(1),
                  .LFSR_SEED(16'hACE1)) u_fifo (
    .clk(clk), .reset(reset),
    .touch_valid(touch_valid), .touch_fill(touch_fill),
    .touch_set(touch_set), .touch_way(touch_way),
    .inval_valid(inval_valid), .inval_set(inval_set),
    .inval_way(inval_way),
    .query_valid(query_valid), .query_set(query_set),
    .lock_mask(lock_mask),
    .victim_valid(vv[1]), .victim_way(vw[1]),
    .victim_none(vn[1]), .flush(flush), .busy(bz[1]));

  set_repl_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS), .POLICY(2),
                  .LFSR_SEED(16'hACE1)) u_rnd (
    .clk(clk), .reset(reset),
    .touch_valid(touch_valid), .touch_fill(touch_fill),
    .touch_set(touch_set), .touch_way(touch_way),
    .inval_valid(inval_valid), .inval_set(inval_set),
    .inval_way(inval_way),
    .query_valid(query_valid), .query_set(query_set),
    .lock_mask(lock_mask),
    .victim_valid(vv[2]), .victim_way(vw[2]),
    .victim_none(vn[2]), .flush(flush), .busy(bz[2]));

  // reference state
  int          tree_m [NS][NW];
  bit [NW-1:0] vld_m  [NS];
  int          ptr_m  [NS];
  logic [15:0] lfsr_m;
  bit          busy_m;
  int          fidx_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit any_in(bit [NW-1:0] av, int lo, int n);
    for (int i = lo; i < lo + n; i++)
      if (av[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_plru(int s, bit [NW-1:0] av);
    int lo, size, node, half;
    bit right;
    lo = 0; size = NW; node = 1;
    while (size > 1) begin
      half  = size / 2;
      right = (tree_m[s][node] != 0);
      if (right && !any_in(av, lo + half, half)) right = 1'b0;
      else if (!right && !any_in(av, lo, half)) right = 1'b1;
      if (right) lo += half;
      node = 2 * node + (right ? 1 : 0);
      size = half;
    end
    return lo;
  endfunction

  // returns NW when every way is locked
  function automatic int exp_way(int pol, int s, bit [NW-1:0] lock);
    bit [NW-1:0] av;
    int st;
    av = ~lock;
    if (av == 0) return NW;
    for (int w = 0; w < NW; w++)
      if (av[w] && !vld_m[s][w]) return w;
    if (pol == 0) return pick_plru(s, av);
    st = (pol == 1) ? ptr_m[s] : int'(lfsr_m) % NW;
    for (int k = 0; k < NW; k++)
      if (av[(st + k) % NW]) return (st + k) % NW;
    return NW;
  endfunction

  // mru=1: path points away from way; mru=0: path points at way
  task automatic mark_path(int s, int w, bit mru);
    int lo, size, node, half;
    lo = 0; size = NW; node = 1;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin
        tree_m[s][node] = mru ? 1 : 0;
        node = 2 * node;
      end else begin
        tree_m[s][node] = mru ? 0 : 1;
        node = 2 * node + 1;
        lo += half;
      end
      size = half;
    end
  endtask

  task automatic clear_set(int s);
    for (int i = 0; i < NW; i++) tree_m[s][i] = 0;
    vld_m[s] = '0;
    ptr_m[s] = 0;
  endtask

  task automatic cycle();
    bit ev;
    int ew [3];
    ev = query_valid && !busy_m && !reset;
    for (int p = 0; p < 3; p++)
      ew[p] = exp_way(p, int'(query_set), lock_mask);
    if (reset) begin
      for (int s = 0; s < NS; s++) clear_set(s);
      lfsr_m = 16'hACE1;
      busy_m = 0;
      fidx_m = 0;
    end else begin
      if (busy_m) begin
        clear_set(fidx_m);
        fidx_m++;
        if (fidx_m == NS) busy_m = 0;
      end else begin
        if (touch_valid) begin
          mark_path(int'(touch_set), int'(touch_way), 1'b1);
          if (touch_fill) begin
            vld_m[touch_set][touch_way] = 1'b1;
            ptr_m[touch_set] = (int'(touch_way) + 1) % NW;
          end
        end
        if (inval_valid) begin
          vld_m[inval_set][inval_way] = 1'b0;
          mark_path(int'(inval_set), int'(inval_way), 1'b0);
        end
        if (flush) begin
          busy_m = 1;
          fidx_m = 0;
        end
      end
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5],
                lfsr_m[15:1]};
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("valid_p%0d", p), int'(vv[p]), int'(ev));
      chk($sformatf("busy_p%0d", p), int'(bz[p]), int'(busy_m));
      if (ev) begin
        chk($sformatf("way_p%0d", p), int'(vw[p]),
            (ew[p] == NW) ? 0 : ew[p]);
        chk($sformatf("none_p%0d", p), int'(vn[p]),
            (ew[p] == NW) ? 1 : 0);
      end
    end
  endtask

  task automatic idle();
    reset = 0; flush = 0;
    touch_valid = 0; touch_fill = 0; touch_set = 0; touch_way = 0;
    inval_valid = 0; inval_set = 0; inval_way = 0;
    query_valid = 0; query_set = 0; lock_mask = 0;
  endtask

  task automatic do_touch(int s, int w, bit fill);
    idle();
    touch_valid = 1; touch_fill = fill;
    touch_set = 3'(s); touch_way = 2'(w);
    cycle();
  endtask

  task automatic do_query(int s, logic [3:0] lk);
    idle();
    query_valid = 1; query_set = 3'(s); lock_mask = lk;
    cycle();
  endtask

  initial begin
    idle();
    reset = 1;
    cycle();
    chk("rst_way", int'(vw[0]), 0);
    chk("rst_none", int'(vn[0]), 0);

    do_query(3, 4'b0000);
    chk("q_after_rst", int'(vw[0]), 0);

    for (int w = 0; w < NW; w++) do_touch(2, w, 1'b1);
    do_query(2, 4'b0000);
    chk("plru_full", int'(vw[0]), 0);
    do_touch(2, 0, 1'b0);
    do_query(2, 4'b0000);
    chk("plru_hit0", int'(vw[0]), 2);
    do_query(2, 4'b0100);
    chk("plru_lock2", int'(vw[0]), 3);
    do_query(2, 4'b1111);
    chk("all_locked", int'(vn[0]), 1);

    idle();
    inval_valid = 1; inval_set = 2; inval_way = 1;
    cycle();
    do_query(2, 4'b0000);
    chk("inval1", int'(vw[0]), 1);
    idle();
    touch_valid = 1; touch_fill = 1; touch_set = 2; touch_way = 3;
    inval_valid = 1; inval_set = 2; inval_way = 3;
    cycle();
    do_query(2, 4'b0010);
    chk("inval_wins", int'(vw[0]), 3);

    for (int w = 0; w < NW; w++) do_touch(0, w, 1'b1);
    do_query(0, 4'b0000);
    chk("fifo_wrap", int'(vw[1]), 0);
    do_query(0, 4'b0001);
    chk("fifo_lock0", int'(vw[1]), 1);

    idle();
    flush = 1;
    cycle();
    for (int i = 0; i < NS; i++) begin
      idle();
      touch_valid = 1; touch_fill = 1; touch_set = 3'(i);
      query_valid = 1; query_set = 3'(i);
      cycle();
    end
    do_query(2, 4'b0000);
    chk("post_flush", int'(vw[0]), 0);

    idle();
    flush = 1;
    cycle();
    idle();
    cycle();
    cycle();
    reset = 1;
    cycle();
    chk("rst_abort", int'(bz[0]), 0);

    for (int i = 0; i < 3000; i++) begin
      idle();
      reset       = ($urandom_range(0, 499) == 0);
      flush       = ($urandom_range(0, 149) == 0);
      touch_valid = $urandom_range(0, 1);
      touch_fill  = $urandom_range(0, 1);
      touch_set   = 3'($urandom_range(0, NS - 1));
      touch_way   = 2'($urandom_range(0, NW - 1));
      inval_valid = ($urandom_range(0, 3) == 0);
      inval_set   = ($urandom_range(0, 3) == 0) ? touch_set
                    : 3'($urandom_range(0, NS - 1));
      inval_way   = 2'($urandom_range(0, NW - 1));
      query_valid = $urandom_range(0, 1);
      query_set   = 3'($urandom_range(0, NS - 1));
      lock_mask   = ($urandom_range(0, 2) == 0)
                    ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_repl_ctrl.md
Name: set_repl_ctrl

Overview:
- Multi-set cache replacement controller; one replacement state per set instead of a single shared set.
- Adds per-way valid tracking (invalid ways are filled first), a per-query way-lock mask, a selectable policy (tree-PLRU, FIFO or LFSR-random) and a sequenced whole-array flush.
- Sits beside the tag/data arrays of a set-associative cache; the cache controller touches ways on hit/fill and queries a victim on miss.

Parameters:
- NUM_WAYS, 4, associativity; power of two, >=2
- NUM_SETS, 8, number of sets; power of two, >=2
- POLICY, 0, 0=tree-PLRU, 1=FIFO, 2=random (16-bit LFSR)
- LFSR_SEED, 16'hACE1, LFSR reset value (POLICY=2 only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- touch_valid  in  1  access update this cycle
- touch_fill  in  1  with touch_valid: the way is being filled (sets its valid bit)
- touch_set  in  $clog2(NUM_SETS)  set touched
- touch_way  in  $clog2(NUM_WAYS)  way touched (becomes MRU)
- inval_valid  in  1  invalidate a way
- inval_set  in  $clog2(NUM_SETS)  set to invalidate
- inval_way  in  $clog2(NUM_WAYS)  way to invalidate
- query_valid  in  1  victim request
- query_set  in  $clog2(NUM_SETS)  set queried
- lock_mask  in  NUM_WAYS  1 = way may not be chosen (sampled with query)
- victim_valid  out  1  response strobe
- victim_way  out  $clog2(NUM_WAYS)  chosen way
- victim_none  out  1  every way is locked; victim_way=0
- flush  in  1  start clearing all sets
- busy  out  1  flush in progress; all request inputs are ignored

Behaviour:
- Storage per set: tree[NUM_WAYS-1:1] (node 1 = root; children 2i and 2i+1; leaf = NUM_WAYS+way), valid[NUM_WAYS-1:0], ptr[$clog2(NUM_WAYS)-1:0]. One global lfsr[15:0] (x^16+x^14+x^13+x^11+1), which steps every cycle.
- Reset (one cycle): all tree, valid and ptr = 0; lfsr = LFSR_SEED; victim_valid=0, victim_way=0, victim_none=0, busy=0; FSM = IDLE. Reset during a flush aborts it.
- Touch (PLRU): walk from the leaf to the root. For each parent, the bit = 1 if the child is even (left), 0 if odd. valid[way] is set when touch_fill=1.
- Touch (FIFO): on touch_fill, ptr = touch_way+1 mod NUM_WAYS. A hit touch does not change ptr.
- Inval: clear valid[way]. For PLRU, also point the path at the way: the parent bit = 0 if the child is even, 1 if odd.
- Simultaneous touch and inval:
  - Same set and same way: inval wins; the way ends invalid.
  - Same set, different ways: apply the touch first, then the inval.
- Query latency is 1 cycle. victim_* is registered and uses the state as it was before any same-cycle touch or inval. victim_valid is a one-cycle pulse.
- Victim selection, with avail = ~lock_mask:
  - If no bit of avail is set: victim_none=1, victim_way=0.
  - Else, if any way is invalid and avail: pick the lowest-index such way.
  - Else, by policy:
    - PLRU: walk from the root. Follow the node bit (1 → 2i+1, 0 → 2i) unless that subtree has no avail way; then take the sibling.
    - FIFO: first avail way scanning upward from ptr, with wrap-around.
    - Random: first avail way scanning upward from lfsr[$clog2(NUM_WAYS)-1:0], with wrap-around.
- Flush FSM:
  - IDLE → FLUSH on flush=1 (only while busy=0).
  - FLUSH clears one set per cycle (tree, valid, ptr = 0), counter 0..NUM_SETS-1, then → IDLE.
  - busy=1 for exactly NUM_SETS cycles, starting the cycle after flush is sampled.
  - While busy: touch, inval and query are dropped; no victim_valid pulse is produced.
  - flush=1 while already busy is ignored.

Decomposition:
- Package repl_pkg:
  - policy enum repl_policy_t {REPL_PLRU, REPL_FIFO, REPL_RANDOM}
  - flush FSM enum {RS_IDLE, RS_FLUSH}
  - LFSR tap constant
- Sub-module plru_tree_pick: combinational; inputs tree bits and avail mask; output way index. Reused by the cache controller's assertions.

Test Plan:
(NUM_WAYS=4, NUM_SETS=8, POLICY=0 unless noted)
- Reset, then query set 3 with lock_mask=0 → next cycle victim_valid=1, victim_way=0, victim_none=0.
- Fill set 2 in the way order 0,1,2,3, then query → victim_way=0. Touch way 0, then query → victim_way=2.
- After the previous scenario, query with lock_mask=4'b0100 → victim_way=3. Query with lock_mask=4'b1111 → victim_none=1, victim_way=0.
- Inval set 2 way 1, then query → victim_way=1. Touch and inval set 2 way 3 in the same cycle → way 3 invalid. Query with lock_mask=4'b0010 → victim_way=3.
- POLICY=1: fill set 0 ways 0,1,2,3 → ptr=0 → victim_way=0. Query with lock_mask=4'b0001 → victim_way=1.
- Assert flush → busy high for 8 cycles; a touch and a query issued during busy produce no effect and no victim_valid. After busy falls, query any set → victim_way=0. Reset asserted mid-flush → busy=0 the next cycle.
